password_entry: RTL and testbench
=================================

PASSWORD_ENTRY -- requirements
Module: password_entry

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning.
  CODE  16'h1234  four BCD digits of the valid password; first-entered digit in [15:12]
  MAX_FAILS  3  consecutive wrong entries that trigger lockout (range 1..7)
  LOCK_CYCLES  1000  lockout duration in clk cycles (at least 1)
  TIMEOUT_CYCLES  5000  inactivity limit in clk cycles while digits are pending (at least 1)
REQ-002 The module SHALL have these ports, one per line: name  direction  width  meaning.
  clk  input  1  single system clock; all state changes on its rising edge
  rst  input  1  asynchronous, active-high reset
  key_valid  input  1  one-cycle strobe; key_digit is valid
  key_digit  input  4  BCD digit 0..9
  key_enter  input  1  one-cycle strobe; submit the entry
  key_clear  input  1  one-cycle strobe; discard the pending digits
  pw  output  1  one-cycle pulse; correct password. Drives the pw input of the security FSM.
  pw_bad  output  1  one-cycle pulse; wrong password
  lockout  output  1  high while entry is blocked
  digit_cnt  output  3  number of digits buffered, 0..4
  fail_cnt  output  3  consecutive wrong entries

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, COLLECT, LOCK.
REQ-004 key_valid with key_digit in 0..9, in IDLE or COLLECT:
  - digit shifts into a 16-bit buffer (new digit enters [3:0]);
  - digit_cnt increments;
  - state goes to COLLECT.
REQ-005 key_valid with key_digit in 10..15 SHALL be ignored, with no state change.
REQ-006 At digit_cnt=4, further digits SHALL be ignored (buffer and count hold).
REQ-007 key_enter in IDLE or COLLECT SHALL be judged correct only when digit_cnt=4 and the buffer equals CODE.
REQ-008 Correct entry, on the clk edge after key_enter is sampled:
  - pw=1 for exactly one cycle;
  - fail_cnt cleared to 0;
  - buffer and digit_cnt cleared;
  - state goes to IDLE.
REQ-009 Wrong entry (including digit_cnt<4, or digit_cnt=0 in IDLE):
  - pw_bad=1 for exactly one cycle;
  - fail_cnt increments;
  - buffer and digit_cnt cleared.
REQ-010 If the incremented fail_cnt equals MAX_FAILS, the state SHALL go to LOCK; otherwise it SHALL go to IDLE.
REQ-011 key_clear SHALL clear the buffer and digit_cnt and set the state to IDLE, leaving fail_cnt unchanged and producing no pulse.
REQ-012 Simultaneous strobes SHALL follow the priority key_clear > key_enter > key_valid; the lower-priority strobes in that cycle are discarded.
REQ-013 In COLLECT, an inactivity timer SHALL reload on every accepted digit.
REQ-014 After TIMEOUT_CYCLES consecutive cycles with no key_valid, key_enter or key_clear strobe, the buffer and digit_cnt SHALL clear and the state SHALL go to IDLE, with no pw_bad and no fail_cnt change.
REQ-015 On entering LOCK:
  - lockout=1;
  - all key strobes ignored;
  - a counter counts LOCK_CYCLES cycles;
  - on expiry, lockout=0, fail_cnt=0, state goes to IDLE.
  lockout SHALL be high for exactly LOCK_CYCLES cycles.
REQ-016 pw and pw_bad SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-017 The timer and counter widths SHALL be derived with $clog2 from LOCK_CYCLES and TIMEOUT_CYCLES; no counter may wrap around.

Reset
REQ-018 While rst=1, regardless of clk:
  - state=IDLE;
  - buffer=0, digit_cnt=0, fail_cnt=0;
  - pw=0, pw_bad=0, lockout=0;
  - timers=0.
REQ-019 Reset asserted mid-entry or mid-lockout SHALL abort the operation; after release the block SHALL behave as after power-up.
REQ-020 The first key strobe SHALL be accepted on the first rising clk edge after rst deasserts.

Verification
Parameters used for all scenarios: LOCK_CYCLES=8, TIMEOUT_CYCLES=16.
REQ-021 Correct code:
  - digits 1,2,3,4 then key_enter -> pw=1 for one cycle on the next edge;
  - digit_cnt=0 and fail_cnt=0 afterwards.
REQ-022 Wrong code and short entry:
  - digits 1,2,3,5 + enter -> pw_bad pulse, fail_cnt=1;
  - digits 1,2 + enter -> pw_bad pulse, fail_cnt=2.
REQ-023 Lockout and release:
  - three wrong entries -> lockout=1 for exactly 8 cycles;
  - correct code sent during lockout -> no pw pulse;
  - after lockout ends -> fail_cnt=0, and the correct code then gives pw.
REQ-024 Timeout, clear and overflow:
  - digits 1,2 then 16 idle cycles -> digit_cnt=0, fail_cnt unchanged;
  - key_clear together with key_enter -> no pulse;
  - digits 1,2,3,4,9 + enter -> pw (fifth digit ignored).
REQ-025 Invalid digit and reset:
  - key_digit=4'hA -> digit_cnt unchanged;
  - rst pulsed in the middle of a cycle while digit_cnt=3 and fail_cnt=2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/password_entry.sv
// -----------------------------------------------------------------------------
// password_entry
//   Keypad password checker. BCD digits are collected into a four-digit buffer.
//   On key_enter the buffer is compared with CODE: a match gives a one-cycle pw
//   pulse, anything else gives a one-cycle pw_bad pulse and bumps the
//   consecutive-failure count. Reaching MAX_FAILS consecutive failures blocks
//   all entry for LOCK_CYCLES cycles. Pending digits are dropped after
//   TIMEOUT_CYCLES cycles without any key strobe.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   key_valid  in   one-cycle strobe, key_digit is valid
//   key_digit  in   [3:0] BCD digit (10..15 are ignored)
//   key_enter  in   one-cycle strobe, submit the entry
//   key_clear  in   one-cycle strobe, discard pending digits
//   pw         out  one-cycle pulse, correct password
//   pw_bad     out  one-cycle pulse, wrong password
//   lockout    out  high while entry is blocked
//   digit_cnt  out  [2:0] number of buffered digits, 0..4
//   fail_cnt   out  [2:0] consecutive wrong entries
// -----------------------------------------------------------------------------
module password_entry #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCK_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  output logic       pw,
  output logic       pw_bad,
  output logic       lockout,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt
);

  // Both counters only ever hold 0..N-1, so $clog2(N) bits are enough.
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        MAX_F     = 3'(MAX_FAILS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOCK    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        buf_q,   buf_d;
  logic [2:0]         cnt_q,   cnt_d;
  logic [2:0]         fail_q,  fail_d;
  logic [LOCK_W-1:0]  lock_q,  lock_d;
  logic [TMO_W-1:0]   tmo_q,   tmo_d;
  logic               pw_q,    pw_d;
  logic               bad_q,   bad_d;
  logic [2:0]         fail_inc;

  assign fail_inc = fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    pw_d    = 1'b0;
    bad_d   = 1'b0;

    case (state_q)
      LOCK: begin
        // Strobes are ignored; lock_q counts down from LOCK_CYCLES-1 so the
        // state stays in LOCK for exactly LOCK_CYCLES cycles.
        if (lock_q == '0) begin
          state_d = IDLE;
          fail_d  = 3'd0;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end

      default: begin
        if (key_clear) begin
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          tmo_d   = '0;
          state_d = IDLE;
        end else if (key_enter) begin
          buf_d = 16'h0000;
          cnt_d = 3'd0;
          tmo_d = '0;
          if (cnt_q == 3'd4 && buf_q == CODE) begin
            pw_d    = 1'b1;
            fail_d  = 3'd0;
            state_d = IDLE;
          end else begin
            bad_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == MAX_F) begin
              state_d = LOCK;
              lock_d  = LOCK_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (key_valid) begin
          // Any key_valid strobe counts as activity, even an ignored digit.
          tmo_d = '0;
          if (key_digit <= 4'd9 && cnt_q < 3'd4) begin
            buf_d   = {buf_q[11:0], key_digit};
            cnt_d   = cnt_q + 3'd1;
            state_d = COLLECT;
          end
        end else if (state_q == COLLECT) begin
          if (tmo_q == TMO_LAST) begin
            buf_d   = 16'h0000;
            cnt_d   = 3'd0;
            tmo_d   = '0;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= 16'h0000;
      cnt_q   <= 3'd0;
      fail_q  <= 3'd0;
      lock_q  <= '0;
      tmo_q   <= '0;
      pw_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      pw_q    <= pw_d;
      bad_q   <= bad_d;
    end
  end

  assign pw        = pw_q;
  assign pw_bad    = bad_q;
  assign lockout   = (state_q == LOCK);
  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_password_entry.sv
// -----------------------------------------------------------------------------
// tb_password_entry
//   Directed scenarios followed by random key traffic for password_entry.
//   The reference model keeps the pending digits in a queue, the failure count
//   and the remaining lockout/idle cycles as plain integers.
// -----------------------------------------------------------------------------
module tb_password_entry;

  localparam logic [15:0] TB_CODE = 16'h1234;
  localparam int          TB_MAX  = 3;
  localparam int          TB_LOCK = 8;
  localparam int          TB_TMO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       pw;
  logic       pw_bad;
  logic       lockout;
  logic [2:0] digit_cnt;
  logic [2:0] fail_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   mq[$];
  int   m_fail = 0;
  int   m_lock = 0;
  int   m_idle = 0;
  logic m_pw   = 1'b0;
  logic m_bad  = 1'b0;

  password_entry #(
    .CODE           (TB_CODE),
    .MAX_FAILS      (TB_MAX),
    .LOCK_CYCLES    (TB_LOCK),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .pw        (pw),
    .pw_bad    (pw_bad),
    .lockout   (lockout),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] code_digit(input int i);
    logic [15:0] c;
    c = TB_CODE >> (12 - 4 * i);
    return c[3:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fail = 0;
    m_lock = 0;
    m_idle = 0;
    m_pw   = 1'b0;
    m_bad  = 1'b0;
  endtask

  // One clock edge of the intended behaviour, given the strobes sampled there.
  task automatic model_step(input logic v, input logic [3:0] d, input logic e, input logic c);
    int val;
    m_pw  = 1'b0;
    m_bad = 1'b0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fail = 0;
    end else if (c) begin
      mq.delete();
      m_idle = 0;
    end else if (e) begin
      val = 0;
      foreach (mq[i]) val = val * 16 + mq[i];
      if (mq.size() == 4 && val == int'(TB_CODE)) begin
        m_pw   = 1'b1;
        m_fail = 0;
      end else begin
        m_bad = 1'b1;
        m_fail++;
        if (m_fail == TB_MAX) m_lock = TB_LOCK;
      end
      mq.delete();
      m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (int'(d) <= 9 && mq.size() < 4) mq.push_back(int'(d));
    end else if (mq.size() > 0) begin
      m_idle++;
      if (m_idle == TB_TMO) begin
        mq.delete();
        m_idle = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("pw",        16'(pw),        16'(m_pw));
    chk("pw_bad",    16'(pw_bad),    16'(m_bad));
    chk("lockout",   16'(lockout),   16'(m_lock > 0));
    chk("digit_cnt", 16'(digit_cnt), 16'(mq.size()));
    chk("fail_cnt",  16'(fail_cnt),  16'(m_fail));
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic e, input logic c);
    key_valid = v;
    key_digit = d;
    key_enter = e;
    key_clear = c;
    @(posedge clk);
    #1;
    model_step(v, d, e, c);
    check_all();
    key_valid = 1'b0;
    key_digit = 4'h0;
    key_enter = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic enter();
    step(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int lock_seen;
    int pw_seen;
    int r;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_digit = 4'h0;
    key_enter = 1'b0;
    key_clear = 1'b0;
    model_reset();

    #12;
    chk("rst_pw",      16'(pw),        16'h0);
    chk("rst_pw_bad",  16'(pw_bad),    16'h0);
    chk("rst_lockout", 16'(lockout),   16'h0);
    chk("rst_dcnt",    16'(digit_cnt), 16'h0);
    chk("rst_fcnt",    16'(fail_cnt),  16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // correct code
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    chk("full_dcnt", 16'(digit_cnt), 16'd4);
    enter();
    chk("good_pw", 16'(pw), 16'h1);
    idle();
    chk("good_pw_one_cycle", 16'(pw), 16'h0);

    // wrong code, then short entry
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd5);
    enter();
    chk("wrong_bad",  16'(pw_bad),   16'h1);
    chk("wrong_fcnt", 16'(fail_cnt), 16'd1);
    digit(4'd1); digit(4'd2);
    enter();
    chk("short_bad",  16'(pw_bad),   16'h1);
    chk("short_fcnt", 16'(fail_cnt), 16'd2);

    // third failure locks; the correct code during lockout is ignored
    enter();
    lock_seen = int'(lockout);
    pw_seen   = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 4)       digit(code_digit(i));
      else if (i == 4) enter();
      else             idle();
      lock_seen += int'(lockout);
      pw_seen   += int'(pw);
    end
    chk("lock_cycles",  16'(lock_seen), 16'(TB_LOCK));
    chk("lock_no_pw",   16'(pw_seen),   16'h0);
    chk("lock_fcnt_0",  16'(fail_cnt),  16'h0);
    for (int i = 0; i < 4; i++) digit(code_digit(i));
    enter();
    chk("after_lock_pw", 16'(pw), 16'h1);

    // timeout of pending digits
    digit(4'd1); digit(4'd2);
    for (int i = 0; i < TB_TMO - 1; i++) idle();
    chk("tmo_pending", 16'(digit_cnt), 16'd2);
    idle();
    chk("tmo_cleared", 16'(digit_cnt), 16'd0);

    // clear beats enter
    for (int i = 0; i < 4; i++) digit(code_digit(i));
    step(1'b0, 4'h0, 1'b1, 1'b1);
    chk("clr_enter_pw",  16'(pw),     16'h0);
    chk("clr_enter_bad", 16'(pw_bad), 16'h0);

    // fifth digit ignored
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4); digit(4'd9);
    enter();
    chk("overflow_pw", 16'(pw), 16'h1);

    // invalid digit
    digit(4'd5);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    chk("invalid_dcnt", 16'(digit_cnt), 16'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // asynchronous reset mid-entry
    enter(); enter();
    digit(4'd7); digit(4'd8); digit(4'd9);
    chk("pre_rst_dcnt", 16'(digit_cnt), 16'd3);
    chk("pre_rst_fcnt", 16'(fail_cnt),  16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pw",      16'(pw),        16'h0);
    chk("arst_pw_bad",  16'(pw_bad),    16'h0);
    chk("arst_lockout", 16'(lockout),   16'h0);
    chk("arst_dcnt",    16'(digit_cnt), 16'h0);
    chk("arst_fcnt",    16'(fail_cnt),  16'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    digit(4'd6);
    chk("post_rst_first_key", 16'(digit_cnt), 16'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)
        digit(code_digit(mq.size() % 4));
      else if (r < 45)
        digit(4'($urandom_range(0, 15)));
      else if (r < 55)
        enter();
      else if (r < 58)
        step(1'b0, 4'h0, 1'b0, 1'b1);
      else if (r < 62)
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r < 64)
        repeat (TB_TMO + 1) idle();
      else
        idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
